mac_result_fifo: RTL and testbench

//  Downstream stage of the a*b+c MAC unit: captures every result presented with

---
 rtl/mac_result_fifo.sv | 177 +++++++++++++++++
 tb/tb_mac_result_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mac_result_fifo
// Description : Result buffer behind the a*b+c MAC unit. Captures each result
//               strobed by validi into a small first-word-fall-through FIFO,
//               hands it out over a valid/ready handshake, keeps a saturating
//               running sum of accepted results and a sticky overflow flag for
//               results dropped while the FIFO was full.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_result_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SUM_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     validi,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     ready_i,
  input  logic                     clr_i,
  output logic                     valido,
  output logic [WIDTH-1:0]         data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [SUM_WIDTH-1:0]     sum
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_ALMOST = c_CNT_W'(DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE    = c_PTR_W'(1);

  // Status FSM encoding
  localparam logic [1:0] c_ST_EMPTY   = 2'd0;
  localparam logic [1:0] c_ST_PARTIAL = 2'd1;
  localparam logic [1:0] c_ST_FULL    = 2'd2;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [SUM_WIDTH-1:0] r_sum;
  logic                 r_overflow;
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [SUM_WIDTH:0]   w_sum_add;
  logic [SUM_WIDTH-1:0] w_sum_sat;

  // Handshake qualifiers: a full FIFO still accepts a word when the head
  // leaves in the same cycle, so the slot freed by the pop is reused.
  assign w_pop  = !w_empty && ready_i;
  assign w_push = validi && (!w_full || w_pop);
  assign w_drop = validi && w_full && !w_pop;

  // Extra carry bit detects wrap; saturate to all-ones instead of wrapping.
  assign w_sum_add = {1'b0, r_sum} + (SUM_WIDTH + 1)'(data_in);
  assign w_sum_sat = w_sum_add[SUM_WIDTH] ? {SUM_WIDTH{1'b1}} : w_sum_add[SUM_WIDTH-1:0];

  // Storage write; the reset cycle never stores the concurrent word
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Read/write pointers, wrapping naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Occupancy counter; simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Running sum; a clear in the same cycle as a push restarts from that word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
    end else if (clr_i) begin
      r_sum <= w_push ? SUM_WIDTH'(data_in) : '0;
    end else if (w_push) begin
      r_sum <= w_sum_sat;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_i) begin
      r_overflow <= 1'b0;
    end
  end

  // Status FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status FSM next-state logic; push-and-pop together always holds state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_EMPTY: begin
        if (w_push) w_state_nxt = c_ST_PARTIAL;
      end
      c_ST_PARTIAL: begin
        if (w_pop && !w_push && (r_count == c_CNT_ONE)) begin
          w_state_nxt = c_ST_EMPTY;
        end else if (w_push && !w_pop && (r_count == c_CNT_ALMOST)) begin
          w_state_nxt = c_ST_FULL;
        end
      end
      c_ST_FULL: begin
        if (w_pop && !w_push) w_state_nxt = c_ST_PARTIAL;
      end
      default: w_state_nxt = c_ST_EMPTY;
    endcase
  end

  // Status FSM output decode
  always_comb begin
    w_empty = 1'b0;
    w_full  = 1'b0;
    case (r_state)
      c_ST_EMPTY:   w_empty = 1'b1;
      c_ST_FULL:    w_full  = 1'b1;
      default: begin
        w_empty = 1'b0;
        w_full  = 1'b0;
      end
    endcase
  end

  // Head word is forced to zero while nothing is buffered
  assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
  assign valido   = !w_empty;
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign sum      = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_mac_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_result_fifo
// Description : Self-checking bench for mac_result_fifo. A queue-based model
//               tracks FIFO contents, sum and overflow; every cycle all
//               outputs are compared against it. Directed scenarios are
//               followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_result_fifo;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int SUM_WIDTH = 16;
  localparam longint c_SUM_MAX = (longint'(1) << SUM_WIDTH) - 1;

  logic                   clk;
  logic                   rst;
  logic                   validi;
  logic [WIDTH-1:0]       data_in;
  logic                   ready_i;
  logic                   clr_i;
  logic                   valido;
  logic [WIDTH-1:0]       data_out;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   overflow;
  logic [SUM_WIDTH-1:0]   sum;

  int     errors = 0;
  int     checks = 0;
  string  stage  = "init";

  // Reference model state
  int     m_q[$];
  longint m_sum = 0;
  bit     m_ovf = 0;

  mac_result_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .SUM_WIDTH(SUM_WIDTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .validi  (validi),
    .data_in (data_in),
    .ready_i (ready_i),
    .clr_i   (clr_i),
    .valido  (valido),
    .data_out(data_out),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .overflow(overflow),
    .sum     (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", stage, tag, obs, exp);
    end
  endtask

  // Compare every output against the model
  task automatic check_all();
    chk("valido",   32'(valido),   32'(m_q.size() > 0));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("count",    32'(count),    32'(m_q.size()));
    chk("data_out", 32'(data_out), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("sum",      32'(sum),      32'(m_sum));
  endtask

  // Drive one cycle of inputs, advance the model, then check outputs
  task automatic cycle(input bit r, input bit v, input int d, input bit rd, input bit c);
    int sz;
    bit pop, push, drop;
    rst     = r;
    validi  = v;
    data_in = WIDTH'(d);
    ready_i = rd;
    clr_i   = c;
    sz   = m_q.size();
    pop  = (sz > 0) && rd;
    push = v && ((sz < DEPTH) || pop);
    drop = v && (sz == DEPTH) && !pop;
    @(posedge clk);
    #1;
    if (r) begin
      m_q.delete();
      m_sum = 0;
      m_ovf = 0;
    end else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(d % (1 << WIDTH));
      if (c) m_sum = push ? longint'(d % (1 << WIDTH)) : 0;
      else if (push) begin
        m_sum = m_sum + longint'(d % (1 << WIDTH));
        if (m_sum > c_SUM_MAX) m_sum = c_SUM_MAX;
      end
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
    end
    check_all();
  endtask

  initial begin
    rst = 1'b1; validi = 1'b0; data_in = '0; ready_i = 1'b0; clr_i = 1'b0;

    // Reset state
    stage = "reset";
    cycle(1, 0, 0, 0, 0);
    chk("rst_data_out", 32'(data_out), 32'd0);

    // Single word through an empty FIFO
    stage = "t1";
    cycle(0, 1, 5, 0, 0);
    chk("t1_head", 32'(data_out), 32'd5);
    chk("t1_sum",  32'(sum),      32'd5);
    cycle(0, 0, 0, 1, 0);
    chk("t1_empty", 32'(empty), 32'd1);
    cycle(0, 0, 0, 1, 0);

    // Fill, drop one, drain in order
    stage = "t2";
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 1, i, 0, 0);
    cycle(0, 1, 9, 0, 0);
    chk("t2_full",     32'(full),     32'd1);
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_sum",      32'(sum),      32'd10);
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", 32'(data_out), 32'(i));
      cycle(0, 0, 0, 1, 0);
    end

    // Push and pop while full, across several fills to wrap pointers
    stage = "t3";
    cycle(1, 0, 0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) cycle(0, 1, 10 * f + i + 1, 0, 0);
      cycle(0, 1, 7, 1, 0);
      chk("t3_count",    32'(count),    32'd4);
      chk("t3_overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
    end

    // Saturation of the running sum, then clear with push
    stage = "t4";
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 257; i++) cycle(0, 1, 255, 1, 0);
    chk("t4_sat", 32'(sum), 32'd65535);
    for (int i = 0; i < 3; i++) cycle(0, 1, 255, 1, 0);
    chk("t4_hold", 32'(sum), 32'd65535);
    cycle(0, 1, 3, 1, 1);
    chk("t4_clr_sum", 32'(sum), 32'd3);
    chk("t4_clr_ovf", 32'(overflow), 32'd0);

    // Reset mid-burst with a concurrent push
    stage = "t5";
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 40 + i, 0, 0);
    cycle(1, 1, 99, 0, 0);
    chk("t5_count",  32'(count),  32'd0);
    chk("t5_valido", 32'(valido), 32'd0);
    chk("t5_sum",    32'(sum),    32'd0);

    // Clear and drop in the same cycle
    stage = "t6";
    for (int i = 0; i < 4; i++) cycle(0, 1, 20 + i, 0, 0);
    cycle(0, 1, 77, 0, 1);
    chk("t6_overflow", 32'(overflow), 32'd1);
    chk("t6_sum",      32'(sum),      32'd0);
    cycle(0, 0, 0, 0, 1);
    chk("t6_clr", 32'(overflow), 32'd0);

    // Randomized traffic
    stage = "rand";
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            (($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255))),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
